microcode_sequencer: RTL
========================

Name: microcode_sequencer

Overview:
- Consumer end of the instruction-decode interface.
- Latches each fetched opcode and presents it to the decoder.
- Takes back the decoder's microcode_start_addr, cycle_length and skip_pc_increment.
- Steps the instruction through its 5/7/12 CPU ticks: issues micro-op addresses, the PC-increment strobe and instruction-done, and handles HALT/SLP and wake.
- Sits between program ROM, decoder, microcode ROM and the PC/register file.

Parameters:
- NOP_OPCODE, 12'hFFB, opcode value loaded into the latch on reset (NOP5).
- STEP_WIDTH, 3, width of the micro-step index. Maximum step is 5.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- clk_en  input  1  CPU tick enable; all state advances only when high
- rom_data  input  12  program ROM word at the current PC
- opcode  output  12  latched opcode to the decoder
- microcode_start_addr  input  7  from the decoder
- cycle_length  input  instr_length  from the decoder (types package: CYCLE5, CYCLE7, CYCLE12)
- skip_pc_increment  input  1  from the decoder
- halt_req  input  1  asserted by microcode of HALT/SLP; sampled only in micro slots
- wake  input  1  interrupt/wake level
- micro_addr  output  10  {start_addr, step}
- micro_valid  output  1  micro-op issue strobe
- fetch  output  1  opcode latched this tick
- pc_increment  output  1  PC advance strobe
- instr_done  output  1  last tick of the instruction
- halted  output  1  in HALT state
- cycle_count  output  4  current tick index within the instruction

Behaviour:
- Clock and reset:
  - One clock, clk. reset_n is synchronous and active-low.
  - Reset values: state=EXEC, cycle_count=0, opcode=NOP_OPCODE, latched length=CYCLE5, latched start=0, latched skip=0, halt_pending=0.
  - Reset forces all strobes to 0 and halted to 0.
  - Reset mid-instruction abandons the instruction with no pc_increment.
- N = 5/7/12 for CYCLE5/CYCLE7/CYCLE12.
- Effective length and start:
  - At c==1 they come from the live decoder inputs.
  - For c>=2 they come from the registers loaded at the c==1 tick.
- Strobes are combinational from registered state and gated by clk_en. With clk_en low, all strobes are 0 and state is frozen.
- States are EXEC and HALT.
- EXEC, per clk_en tick with count c:
  - c==0: fetch=1, opcode<=rom_data at the clock edge. The decoder output is valid from c==1.
  - c==1: latch cycle_length, microcode_start_addr and skip_pc_increment.
  - Odd c with c<N: micro_valid=1, step=(c-1)/2, micro_addr={start, step}.
    - CYCLE5: slots at c=1,3.
    - CYCLE7: slots at c=1,3,5.
    - CYCLE12: slots at c=1,3,5,7,9,11 (steps 0..5).
  - halt_req sampled high in a micro slot sets halt_pending.
  - c==N-1 (final): instr_done=1 and pc_increment=!skip_latched.
    - Next c=0.
    - If halt_pending, or halt_req is high in this tick's micro slot (CYCLE12 c=11), go to HALT and clear halt_pending.
  - Otherwise c<=c+1.
- HALT:
  - halted=1; fetch, micro_valid, pc_increment and instr_done are 0; c held at 0.
  - wake high on a clk_en tick means the next tick is EXEC c==0.
- wake in EXEC is ignored.
- cycle_count wraps only at N-1 and never exceeds 11.

Test Plan:
- Reset: hold reset_n=0 for 3 clk_en ticks mid-instruction (c=3) -> opcode=12'hFFB, cycle_count=0, all strobes 0, no pc_increment. After release, the first tick has fetch=1.
- JP (rom_data=12'h012, CYCLE5, clk_en every clk):
  - fetch at tick 0.
  - micro_valid at ticks 1 and 3 with micro_addr 10'h000 and 10'h001.
  - instr_done=1 and pc_increment=1 at tick 4.
  - Next fetch at tick 5.
- CALL (12'h4AB, CYCLE7, skip=1):
  - micro_addr 10'h020/021/022 at ticks 1/3/5.
  - instr_done at tick 6 with pc_increment=0.
- RETD (12'h1xx, CYCLE12):
  - micro_valid at ticks 1,3,5,7,9,11 with steps 0..5 (addr 10'h008..00D).
  - Tick 11 has micro_valid and instr_done both high.
  - pc_increment=0.
- HALT:
  - halt_req pulsed at tick 1 of a CYCLE5 instruction -> instr_done at tick 4, then halted=1, with no fetch for 20 ticks while wake=0.
  - wake=1 -> halted=0 and fetch=1 on the next tick.
  - Repeat with halt_req at CYCLE12 tick 11 -> halted on the following tick.
- clk_en high one clk in three on the JP case -> identical tick sequence stretched 3x; no strobe is ever high while clk_en=0.

Source files
------------

// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the instruction-decode interface.
//   instr_length : number of CPU ticks an instruction occupies (5, 7 or 12),
//                  reported by the decoder and consumed by the sequencer.
package microcode_sequencer_pkg;

  typedef enum logic [1:0] {
    CYCLE5  = 2'd0,
    CYCLE7  = 2'd1,
    CYCLE12 = 2'd2
  } instr_length;

endpackage

// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//
// Consumer end of the instruction-decode interface. Latches each fetched
// opcode for the decoder, takes back the decoder's microcode start address,
// instruction length and PC-skip flag, then walks the instruction through its
// 5/7/12 CPU ticks. On odd ticks it issues a micro-op address {start, step};
// on the last tick it raises instr_done and (unless skipped) pc_increment.
// HALT/SLP microcode raises halt_req in a micro slot; the sequencer parks in
// HALT after the current instruction completes and resumes on wake.
//
// Ports
//   clk                  in   system clock
//   reset_n              in   synchronous active-low reset
//   clk_en               in   CPU tick enable; state advances only when high
//   rom_data[11:0]       in   program ROM word at the current PC
//   opcode[11:0]         out  latched opcode presented to the decoder
//   microcode_start_addr in   7-bit micro-routine base from the decoder
//   cycle_length         in   instruction length from the decoder
//   skip_pc_increment    in   decoder request to suppress the PC advance
//   halt_req             in   HALT/SLP request, honoured only in micro slots
//   wake                 in   wake/interrupt level, honoured only in HALT
//   micro_addr[9:0]      out  {start_addr, step} to the microcode ROM
//   micro_valid          out  micro-op issue strobe
//   fetch                out  opcode is latched at the end of this tick
//   pc_increment         out  PC advance strobe
//   instr_done           out  last tick of the instruction
//   halted               out  sequencer is parked in HALT
//   cycle_count[3:0]     out  tick index within the current instruction
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter logic [11:0] NOP_OPCODE = 12'hFFB,
  parameter int unsigned STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [11:0]           rom_data,
  output logic [11:0]           opcode,
  input  logic [6:0]            microcode_start_addr,
  input  instr_length           cycle_length,
  input  logic                  skip_pc_increment,
  input  logic                  halt_req,
  input  logic                  wake,
  output logic [6+STEP_WIDTH:0] micro_addr,
  output logic                  micro_valid,
  output logic                  fetch,
  output logic                  pc_increment,
  output logic                  instr_done,
  output logic                  halted,
  output logic [3:0]            cycle_count
);

  typedef enum logic {
    ST_EXEC = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Index of the final tick for a given instruction length.
  function automatic logic [3:0] last_tick(input instr_length len);
    case (len)
      CYCLE7:  last_tick = 4'd6;
      CYCLE12: last_tick = 4'd11;
      default: last_tick = 4'd4;
    endcase
  endfunction

  // Registered control state
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] opcode_q, opcode_d;
  instr_length len_q, len_d;
  logic [6:0]  start_q, start_d;
  logic        skip_q, skip_d;
  logic        pend_q, pend_d;

  // Decode of the current tick
  logic                  in_exec;
  logic                  active;
  instr_length           eff_len;
  logic [6:0]            eff_start;
  logic [3:0]            last_c;
  logic                  slot;
  logic                  is_final;
  logic                  halt_hit;
  logic [STEP_WIDTH-1:0] step;

  // The decoder output only becomes valid at tick 1, so that tick uses the
  // live inputs; later ticks use the copies captured at tick 1.
  assign in_exec   = (state_q == ST_EXEC);
  assign active    = clk_en && reset_n;
  assign eff_len   = (cnt_q == 4'd1) ? cycle_length : len_q;
  assign eff_start = (cnt_q == 4'd1) ? microcode_start_addr : start_q;
  assign last_c    = last_tick(eff_len);

  // Micro slots sit on odd ticks; the step index is (c-1)/2 = c[3:1].
  assign slot      = in_exec && cnt_q[0] && (cnt_q <= last_c);
  assign is_final  = in_exec && (cnt_q >= last_c);
  assign halt_hit  = slot && halt_req;
  assign step      = STEP_WIDTH'(cnt_q[3:1]);

  // Outputs: strobes are gated by the tick enable and by reset so an
  // abandoned instruction never leaks a pc_increment.
  assign fetch        = active && in_exec && (cnt_q == 4'd0);
  assign micro_valid  = active && slot;
  assign micro_addr   = {eff_start, step};
  assign instr_done   = active && is_final;
  assign pc_increment = active && is_final && !skip_q;
  assign halted       = reset_n && (state_q == ST_HALT);
  assign cycle_count  = cnt_q;
  assign opcode       = opcode_q;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    len_d    = len_q;
    start_d  = start_q;
    skip_d   = skip_q;
    pend_d   = pend_q;

    if (clk_en) begin
      case (state_q)
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            opcode_d = rom_data;
          end
          if (cnt_q == 4'd1) begin
            len_d   = cycle_length;
            start_d = microcode_start_addr;
            skip_d  = skip_pc_increment;
          end
          if (is_final) begin
            cnt_d = 4'd0;
            // A request raised in the final slot itself (CYCLE12 tick 11)
            // halts immediately, as does one remembered from earlier slots.
            if (pend_q || halt_hit) begin
              state_d = ST_HALT;
              pend_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (halt_hit) begin
              pend_d = 1'b1;
            end
          end
        end
        ST_HALT: begin
          cnt_d = 4'd0;
          if (wake) begin
            state_d = ST_EXEC;
          end
        end
        default: begin
          state_d = ST_EXEC;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_EXEC;
      cnt_q    <= 4'd0;
      opcode_q <= NOP_OPCODE;
      len_q    <= CYCLE5;
      start_q  <= 7'd0;
      skip_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      start_q  <= start_d;
      skip_q   <= skip_d;
      pend_q   <= pend_d;
    end
  end

endmodule
